// File: rtl/arbiter.sv
// Parameterised request arbiter: fixed priority or round robin, optional grant blocking.
// Defining ARBITER_ASSERT_EN compiles in simulation-only output consistency checks.

`ifdef ARBITER_ASSERT_EN
module arbiter_checker #(
    parameter int PORTS = 4,
    parameter int W     = 2
) (
    input logic             clk,
    input logic             rst,
    input logic [PORTS-1:0] grant,
    input logic             grant_valid,
    input logic [W-1:0]     grant_encoded
);

    // Output consistency checks, sampled on every edge outside reset
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant))
                else $error("arbiter: grant not one-hot or zero: %b", grant);
            assert (grant_valid == (|grant))
                else $error("arbiter: grant_valid %b vs grant %b", grant_valid, grant);
            assert (grant_valid ? (grant[grant_encoded] == 1'b1) : (grant_encoded == W'(0)))
                else $error("arbiter: grant_encoded %0d vs grant %b", grant_encoded, grant);
        end
    end

endmodule
`endif

module arbiter #(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 0,
    parameter int ARB_BLOCK             = 0,
    parameter int ARB_BLOCK_ACK         = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 0,
    localparam int W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] acknowledge,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [W-1:0]     grant_encoded
);

    logic [PORTS-1:0] grant_r, grant_next_s;
    logic [PORTS-1:0] mask_r, mask_next_s;
    logic [PORTS-1:0] masked_req_s, pick_req_s, onehot_s;
    logic [W-1:0]     enc_r, enc_next_s, idx_s;
    logic             valid_r, valid_next_s, hold_s;

    function automatic logic [W-1:0] pick_index(input logic [PORTS-1:0] req);
        logic [W-1:0] idx;
        idx = {W{1'b0}};
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                idx = req[i] ? W'(i) : idx;
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                idx = req[i] ? W'(i) : idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [PORTS-1:0] index_to_onehot(input logic [W-1:0] idx);
        logic [PORTS-1:0] oh;
        for (int i = 0; i < PORTS; i++) begin
            oh[i] = (idx == W'(i));
        end
        return oh;
    endfunction

    // The mask keeps only ports strictly below the winner in priority order
    function automatic logic [PORTS-1:0] next_mask(input logic [W-1:0] idx);
        logic [PORTS-1:0] ones;
        logic [31:0]      sh;
        ones = {PORTS{1'b1}};
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
            sh = 32'(idx) + 32'd1;
            return ones << sh;
        end else begin
            sh = 32'(PORTS) - 32'(idx);
            return ones >> sh;
        end
    endfunction

    // Candidate selection: masked requests first in round robin, else the raw request
    always_comb begin
        masked_req_s = request & mask_r;
        pick_req_s   = request;
        if ((ARB_TYPE_ROUND_ROBIN != 0) && (masked_req_s != {PORTS{1'b0}})) begin
            pick_req_s = masked_req_s;
        end else begin
            pick_req_s = request;
        end
        idx_s    = pick_index(pick_req_s);
        onehot_s = index_to_onehot(idx_s);
    end

    // Hold decision and next grant/mask state
    always_comb begin
        hold_s       = 1'b0;
        grant_next_s = grant_r;
        valid_next_s = valid_r;
        enc_next_s   = enc_r;
        mask_next_s  = mask_r;
        if (ARB_BLOCK != 0) begin
            if (ARB_BLOCK_ACK != 0) begin
                hold_s = valid_r && ((grant_r & acknowledge) == {PORTS{1'b0}});
            end else begin
                hold_s = (grant_r & request) != {PORTS{1'b0}};
            end
        end else begin
            hold_s = 1'b0;
        end

        if (hold_s) begin
            grant_next_s = grant_r;
        end else if (request != {PORTS{1'b0}}) begin
            grant_next_s = onehot_s;
            valid_next_s = 1'b1;
            enc_next_s   = idx_s;
            if (ARB_TYPE_ROUND_ROBIN != 0) begin
                mask_next_s = next_mask(idx_s);
            end else begin
                mask_next_s = mask_r;
            end
        end else begin
            grant_next_s = {PORTS{1'b0}};
            valid_next_s = 1'b0;
            enc_next_s   = {W{1'b0}};
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r <= {PORTS{1'b0}};
            valid_r <= 1'b0;
            enc_r   <= {W{1'b0}};
            mask_r  <= {PORTS{1'b0}};
        end else begin
            grant_r <= grant_next_s;
            valid_r <= valid_next_s;
            enc_r   <= enc_next_s;
            mask_r  <= mask_next_s;
        end
    end

    assign grant         = grant_r;
    assign grant_valid   = valid_r;
    assign grant_encoded = enc_r;

`ifdef ARBITER_ASSERT_EN
    arbiter_checker #(.PORTS(PORTS), .W(W)) u_checker (
        .clk          (clk),
        .rst          (rst),
        .grant        (grant_r),
        .grant_valid  (valid_r),
        .grant_encoded(enc_r)
    );
`endif

endmodule

// File: tb/tb_arbiter.sv
// Directed self-checking bench for arbiter: several parameterisations share one stimulus.
module tb_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] request = 4'b0000;
    logic [3:0] acknowledge = 4'b0000;
    int         n_cmp = 0;
    int         n_err = 0;

    logic [3:0] g_fl, g_fm, g_rr, g_rm, g_ba, g_br;
    logic       v_fl, v_fm, v_rr, v_rm, v_ba, v_br;
    logic [1:0] e_fl, e_fm, e_rr, e_rm, e_ba, e_br;

    always #5 clk = ~clk;

    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1))
        u_fl (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
              .grant(g_fl), .grant_valid(v_fl), .grant_encoded(e_fl));
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(0))
        u_fm (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
              .grant(g_fm), .grant_valid(v_fm), .grant_encoded(e_fm));
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1))
        u_rr (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
              .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(0))
        u_rm (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
              .grant(g_rm), .grant_valid(v_rm), .grant_encoded(e_rm));
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1))
        u_ba (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
              .grant(g_ba), .grant_valid(v_ba), .grant_encoded(e_ba));
    arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(1))
        u_br (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
              .grant(g_br), .grant_valid(v_br), .grant_encoded(e_br));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        request = 4'b0000;
        acknowledge = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if ({g_fl, g_fm, g_rr, g_rm, g_ba, g_br} !== 24'd0) begin
            $display("FAIL reset_grant: got %h want 0", {g_fl, g_fm, g_rr, g_rm, g_ba, g_br}); n_err++;
        end
        n_cmp++;
        if ({v_fl, v_fm, v_rr, v_rm, v_ba, v_br} !== 6'd0) begin
            $display("FAIL reset_valid: got %b want 0", {v_fl, v_fm, v_rr, v_rm, v_ba, v_br}); n_err++;
        end
        n_cmp++;
        if ({e_fl, e_fm, e_rr, e_rm, e_ba, e_br} !== 12'd0) begin
            $display("FAIL reset_enc: got %h want 0", {e_fl, e_fm, e_rr, e_rm, e_ba, e_br}); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_fixed();
        do_reset();
        request = 4'b1010;
        step();
        if ({g_fl, e_fl, v_fl} !== {4'b0010, 2'd1, 1'b1}) begin
            $display("FAIL fixed_lsb_1010: got %b/%0d/%b want 0010/1/1", g_fl, e_fl, v_fl); n_err++;
        end
        n_cmp++;
        if ({g_fm, e_fm, v_fm} !== {4'b1000, 2'd3, 1'b1}) begin
            $display("FAIL fixed_msb_1010: got %b/%0d/%b want 1000/3/1", g_fm, e_fm, v_fm); n_err++;
        end
        n_cmp++;
        request = 4'b0110;
        step();
        if ({g_fl, e_fl} !== {4'b0010, 2'd1}) begin
            $display("FAIL fixed_lsb_0110: got %b/%0d want 0010/1", g_fl, e_fl); n_err++;
        end
        n_cmp++;
        if ({g_fm, e_fm} !== {4'b0100, 2'd2}) begin
            $display("FAIL fixed_msb_0110: got %b/%0d want 0100/2", g_fm, e_fm); n_err++;
        end
        n_cmp++;
        request = 4'b0001;
        step();
        if ({g_fm, e_fm, v_fm} !== {4'b0001, 2'd0, 1'b1}) begin
            $display("FAIL fixed_msb_0001: got %b/%0d/%b want 0001/0/1", g_fm, e_fm, v_fm); n_err++;
        end
        n_cmp++;
        request = 4'b0000;
        step();
        if ({g_fl, e_fl, v_fl, g_fm, e_fm, v_fm} !== 14'd0) begin
            $display("FAIL fixed_idle: got %b/%0d/%b %b/%0d/%b want zeros", g_fl, e_fl, v_fl, g_fm, e_fm, v_fm); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_l [5];
        logic [3:0] exp_m [5];
        exp_l = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_m = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        do_reset();
        request = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            if (g_rr !== exp_l[i]) begin
                $display("FAIL rr_lsb[%0d]: got %b want %b", i, g_rr, exp_l[i]); n_err++;
            end
            n_cmp++;
            if (g_rm !== exp_m[i]) begin
                $display("FAIL rr_msb[%0d]: got %b want %b", i, g_rm, exp_m[i]); n_err++;
            end
            n_cmp++;
        end
        request = 4'b0000;
        step();
        if ({g_rr, v_rr} !== 5'b00000) begin
            $display("FAIL rr_idle: got %b/%b want 0000/0", g_rr, v_rr); n_err++;
        end
        n_cmp++;
        // mask 1110 survives the idle cycle, so bit 2 beats bit 0
        request = 4'b0101;
        step();
        if ({g_rr, e_rr} !== {4'b0100, 2'd2}) begin
            $display("FAIL rr_mask_kept: got %b/%0d want 0100/2", g_rr, e_rr); n_err++;
        end
        n_cmp++;
        step();
        if ({g_rr, e_rr} !== {4'b0001, 2'd0}) begin
            $display("FAIL rr_wrap: got %b/%0d want 0001/0", g_rr, e_rr); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_block_ack();
        do_reset();
        request = 4'b0001;
        step();
        if (g_ba !== 4'b0001) begin
            $display("FAIL blk_ack_first: got %b want 0001", g_ba); n_err++;
        end
        n_cmp++;
        request = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            if ({g_ba, v_ba} !== {4'b0001, 1'b1}) begin
                $display("FAIL blk_ack_hold[%0d]: got %b/%b want 0001/1", i, g_ba, v_ba); n_err++;
            end
            n_cmp++;
        end
        acknowledge = 4'b0001;
        request = 4'b0100;
        step();
        if ({g_ba, e_ba} !== {4'b0100, 2'd2}) begin
            $display("FAIL blk_ack_b2b: got %b/%0d want 0100/2", g_ba, e_ba); n_err++;
        end
        n_cmp++;
        request = 4'b0001;
        step();
        if (g_ba !== 4'b0100) begin
            $display("FAIL blk_ack_foreign: got %b want 0100", g_ba); n_err++;
        end
        n_cmp++;
        acknowledge = 4'b0100;
        request = 4'b0000;
        step();
        if ({g_ba, v_ba, e_ba} !== 7'd0) begin
            $display("FAIL blk_ack_release: got %b/%b/%0d want 0000/0/0", g_ba, v_ba, e_ba); n_err++;
        end
        n_cmp++;
        acknowledge = 4'b0000;
    endtask

    task automatic test_block_req();
        do_reset();
        request = 4'b0100;
        step();
        if (g_br !== 4'b0100) begin
            $display("FAIL blk_req_first: got %b want 0100", g_br); n_err++;
        end
        n_cmp++;
        request = 4'b0101;
        acknowledge = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            if ({g_br, e_br} !== {4'b0100, 2'd2}) begin
                $display("FAIL blk_req_hold[%0d]: got %b/%0d want 0100/2", i, g_br, e_br); n_err++;
            end
            n_cmp++;
        end
        acknowledge = 4'b0000;
        request = 4'b0001;
        step();
        if ({g_br, e_br, v_br} !== {4'b0001, 2'd0, 1'b1}) begin
            $display("FAIL blk_req_switch: got %b/%0d/%b want 0001/0/1", g_br, e_br, v_br); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        do_reset();
        request = 4'b0010;
        step();
        if ({g_fl, g_ba} !== {4'b0010, 4'b0010}) begin
            $display("FAIL arst_pre: got %b %b want 0010 0010", g_fl, g_ba); n_err++;
        end
        n_cmp++;
        #2;
        rst = 1'b1;
        #1;
        if ({g_fl, v_fl, e_fl, g_ba, v_ba} !== 12'd0) begin
            $display("FAIL arst_immediate: got %b/%b/%0d %b/%b want zeros", g_fl, v_fl, e_fl, g_ba, v_ba); n_err++;
        end
        n_cmp++;
        request = 4'b0000;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if ({v_fl, v_ba, g_ba} !== 6'd0) begin
                $display("FAIL arst_after[%0d]: got %b %b %b want 0 0 0000", i, v_fl, v_ba, g_ba); n_err++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_block_ack();
        test_block_req();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesters, 1..32.
REQ-002 SHALL have parameter ARB_TYPE_ROUND_ROBIN, default 0: 0 = fixed priority, 1 = round robin.
REQ-003 SHALL have parameter ARB_BLOCK, default 0: 1 = hold grant until released.
REQ-004 SHALL have parameter ARB_BLOCK_ACK, default 1: with ARB_BLOCK=1, release on acknowledge (1) or on request drop (0).
REQ-005 SHALL have parameter ARB_LSB_HIGH_PRIORITY, default 0: 1 = lowest index wins, 0 = highest index wins.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port request, input, PORTS bits: per-port request.
REQ-009 SHALL have port acknowledge, input, PORTS bits: per-port release, used only when ARB_BLOCK=1 and ARB_BLOCK_ACK=1.
REQ-010 SHALL have port grant, output, PORTS bits: one-hot registered grant, or all zero.
REQ-011 SHALL have port grant_valid, output, 1 bit: high iff grant is nonzero.
REQ-012 SHALL have port grant_encoded, output, W bits: binary index of the granted port; W = $clog2(PORTS), and W = 1 when PORTS = 1.

Function
REQ-013 SHALL register all outputs; a decision made from the inputs in cycle N SHALL appear after edge N+1 (one-cycle latency).
REQ-014 SHALL hold grant each cycle when ARB_BLOCK=1, ARB_BLOCK_ACK=0 and (grant & request) != 0.
REQ-015 SHALL hold grant each cycle when ARB_BLOCK=1, ARB_BLOCK_ACK=1, grant_valid=1 and (grant & acknowledge) == 0, regardless of request.
REQ-016 SHALL, when not holding and request == 0, clear grant, grant_valid and grant_encoded to 0.
REQ-017 SHALL, in fixed priority with requests pending, grant the lowest set index (LSB_HIGH=1) or the highest set index (LSB_HIGH=0).
REQ-018 SHALL, in round robin, keep a PORTS-bit mask register and apply the fixed-priority rule to request & mask; if that result is zero, it SHALL apply the rule to the unmasked request.
REQ-019 SHALL, in round robin with granted index k, set the next mask to all-ones shifted left by k+1 (LSB_HIGH=1) or to all-ones shifted right by PORTS-k (LSB_HIGH=0).
REQ-020 SHALL leave the mask unchanged while holding or idle.
REQ-021 SHALL allow a new grant, when acknowledge releases a grant and requests are pending in the same cycle, on the next edge with no idle cycle (back-to-back).
REQ-022 SHALL ignore acknowledge on non-granted ports.
REQ-023 SHALL always drive grant_encoded consistent with grant.

Reset
REQ-024 SHALL, while rst=1, asynchronously force grant=0, grant_valid=0, grant_encoded=0 and mask=0.
REQ-025 SHALL, after reset deasserts mid-operation, start arbitration fresh with no retained grant.

Configuration
REQ-026 SHALL, when macro ARBITER_ASSERT_EN is defined, include simulation-only checks that report an error on any clock edge outside reset where: grant is not one-hot or zero, grant_valid != |grant, or grant_encoded mismatches grant.
REQ-027 SHALL, when ARBITER_ASSERT_EN is undefined, compile none of these checks; synthesized behaviour SHALL be identical either way.

Verification
REQ-028 SHALL pass this case: PORTS=4, fixed, LSB_HIGH=1, no block, request=4'b1010 -> next cycle grant=4'b0010, grant_encoded=1, grant_valid=1.
REQ-029 SHALL pass this case: same configuration, LSB_HIGH=0, request=4'b1010 -> grant=4'b1000, grant_encoded=3.
REQ-030 SHALL pass this case: round robin, LSB_HIGH=1, request=4'b1111 held 5 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-031 SHALL pass this case: ARB_BLOCK=1, ARB_BLOCK_ACK=1, port 0 granted, request drops, acknowledge=0 -> grant stays 0001; acknowledge=4'b0001 with request=4'b0100 -> next grant=0100.
REQ-032 SHALL pass this case: ARB_BLOCK=1, ARB_BLOCK_ACK=0, port 2 granted, higher-priority request=4'b0101 -> grant stays 0100 until bit 2 drops, then grant=0001.
REQ-033 SHALL pass this case: rst asserted between clock edges while grant=0010 -> outputs go to 0 immediately; after release with request=0, grant_valid stays 0.
